// File: rtl/laser_pulse_pkg.sv
// ---------------------------------------------------------------------------
// laser_pulse_pkg
//
// Purpose:
//   Shared definitions for the laser trigger pulse generator.
//   - mode_e: the channel-select encoding taken from control register 0.
//   - Per-mode helper functions that tell a channel whether it is selected
//     and at which cycle offset within the period its pulse starts.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package laser_pulse_pkg;

  // Number of laser trigger channels driven by the block.
  localparam int unsigned NUM_CH = 3;

  // Channel select encoding. MODE_ALL runs every channel, staggered in time.
  typedef enum logic [1:0] {
    MODE_P1  = 2'd0,
    MODE_P2  = 2'd1,
    MODE_P3  = 2'd2,
    MODE_ALL = 2'd3
  } mode_e;

  // Channel ch (0-based) fires in MODE_ALL, or when the mode names it.
  function automatic logic channel_selected(mode_e mode, int unsigned ch);
    return (mode == MODE_ALL) || ({30'd0, mode} == ch);
  endfunction

  // Start offset of channel ch inside the period. Single-channel modes always
  // fire at phase 0; MODE_ALL spreads the channels by one stagger step each so
  // that their pulses never coincide.
  function automatic int unsigned channel_offset(mode_e mode, int unsigned ch,
                                                 int unsigned stagger);
    return (mode == MODE_ALL) ? ch * stagger : 32'd0;
  endfunction

endpackage

// File: rtl/laser_pulse_window.sv
// ---------------------------------------------------------------------------
// pulse_window
//
// Purpose:
//   One laser trigger channel. Raises its output for PW cycles whenever the
//   shared period counter sits inside [offset, offset + PW), provided the
//   block is enabled and this channel is selected. The output is registered
//   so the laser driver pin sees a clean, glitch-free level.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   en      in   run enable; low forces the output low at the next edge
//   sel     in   channel selected by the active mode
//   cnt     in   current period counter value
//   offset  in   first counter value of this channel's pulse
//   pulse   out  registered trigger output
// ---------------------------------------------------------------------------
module pulse_window #(
  parameter int          CW = 32,
  parameter int unsigned PW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sel,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] offset,
  output logic          pulse
);

  logic [CW-1:0] win_end;
  logic          in_window;

  // The window end never overflows: offset + PW stays within PERIOD, which is
  // itself representable in CW bits.
  always_comb begin
    win_end   = offset + CW'(PW);
    in_window = (cnt >= offset) && (cnt < win_end);
  end

  // Registered trigger. Dropping en clears the output on the very next edge,
  // truncating any pulse in flight, which is the safe behaviour for a laser.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= en & sel & in_window;
    end
  end

endmodule

// File: rtl/laser_pulse.sv
// ---------------------------------------------------------------------------
// laser_pulse
//
// Purpose:
//   Periodic fixed-width trigger pulse generator for the LiDAR transmit path.
//   A free-running period counter (cleared while disabled) drives three
//   pulse_window channels. The active mode is captured into mode_q only while
//   idle or on the last cycle of a period, so mode changes while running take
//   effect cleanly at the next period boundary.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RSTn     in   synchronous active-high reset (name kept for compatibility)
//   EN       in   run enable (control register 0, bit 0)
//   MODE     in   channel select (control register 0, bits 2:1)
//   PULSE_1  out  laser 1 trigger, registered
//   PULSE_2  out  laser 2 trigger, registered
//   PULSE_3  out  laser 3 trigger, registered
// ---------------------------------------------------------------------------
module laser_pulse
  import laser_pulse_pkg::*;
#(
  parameter int unsigned PERIOD  = 100_000,
  parameter int unsigned PW      = 5,
  parameter int unsigned STAGGER = 1_000,
  parameter int          CW      = 32
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       EN,
  input  logic [1:0] MODE,
  output logic       PULSE_1,
  output logic       PULSE_2,
  output logic       PULSE_3
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0]       cnt;
  logic                wrap;
  mode_e               mode_q;
  logic [CW-1:0]       chan_off [NUM_CH];
  logic [NUM_CH-1:0]   chan_sel;
  logic [NUM_CH-1:0]   pulse_vec;

  assign wrap = (cnt == CNT_LAST);

  // Period counter. Held at zero while disabled so that enabling always
  // starts a fresh period at phase 0 and the first pulse fires immediately.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      cnt <= '0;
    end else if (!EN) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Active mode. Tracks MODE freely while idle; while running it only updates
  // on the wrap cycle so the current period's pattern always completes and no
  // runt or doubled pulse can appear.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      mode_q <= MODE_P1;
    end else if (!EN || wrap) begin
      mode_q <= mode_e'(MODE);
    end
  end

  // One window per channel; offset and select come from the captured mode.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan_sel[k] = channel_selected(mode_q, k);
    assign chan_off[k] = CW'(channel_offset(mode_q, k, STAGGER));

    pulse_window #(
      .CW (CW),
      .PW (PW)
    ) u_window (
      .clk    (CLK),
      .rst    (RSTn),
      .en     (EN),
      .sel    (chan_sel[k]),
      .cnt    (cnt),
      .offset (chan_off[k]),
      .pulse  (pulse_vec[k])
    );
  end

  assign PULSE_1 = pulse_vec[0];
  assign PULSE_2 = pulse_vec[1];
  assign PULSE_3 = pulse_vec[2];

endmodule

// File: tb/tb_laser_pulse.sv
// ---------------------------------------------------------------------------
// tb_laser_pulse
//
// Purpose:
//   Self-checking bench for laser_pulse (PERIOD=100, PW=5, STAGGER=20).
//   The driver issues one input set per clock and pushes the expected outputs
//   after that edge into a queue; the monitor pops one entry per clock and
//   compares it with the DUT outputs. Expectations come from a model that
//   works from run start times and a per-edge history of MODE.
// ---------------------------------------------------------------------------
module tb_laser_pulse;

  localparam int unsigned PERIOD  = 100;
  localparam int unsigned PW      = 5;
  localparam int unsigned STAGGER = 20;
  localparam int          CW      = 32;
  localparam int          MAX_FAIL_PRINTS = 25;

  logic       CLK;
  logic       RSTn;
  logic       EN;
  logic [1:0] MODE;
  logic       PULSE_1;
  logic       PULSE_2;
  logic       PULSE_3;

  int checks;
  int errors;

  // Scoreboard of expected {PULSE_3, PULSE_2, PULSE_1} after each edge.
  logic [2:0] exp_q [$];

  // Model state: input history per driven edge and the edge a run started on.
  logic       rst_hist  [$];
  logic [1:0] mode_hist [$];
  int         run_start;

  laser_pulse #(
    .PERIOD  (PERIOD),
    .PW      (PW),
    .STAGGER (STAGGER),
    .CW      (CW)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .EN      (EN),
    .MODE    (MODE),
    .PULSE_1 (PULSE_1),
    .PULSE_2 (PULSE_2),
    .PULSE_3 (PULSE_3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs after an edge, computed from the run's start edge: the
  // phase inside the period picks the window, and the mode in force for a
  // period is whatever MODE was on the edge just before that period began
  // (or mode 0 if that edge was a reset).
  function automatic logic [2:0] model_edge(input int e, input logic r, input logic en);
    logic [2:0] res;
    int         phase;
    int         idx;
    int         src;
    int         m;
    int         off;
    res = 3'b000;
    if (r || !en) begin
      run_start = -1;
    end else begin
      if (run_start < 0) run_start = e;
      phase = (e - run_start) % PERIOD;
      idx   = (e - run_start) / PERIOD;
      src   = run_start + idx * PERIOD - 1;
      if (src < 0 || rst_hist[src]) m = 0;
      else                           m = int'(mode_hist[src]);
      for (int k = 0; k < 3; k++) begin
        off = (m == 3) ? k * STAGGER : 0;
        if ((m == 3 || m == k) && phase >= off && phase < off + PW)
          res[k] = 1'b1;
      end
    end
    return res;
  endfunction

  // Drive one input set for n consecutive edges and record expectations.
  task automatic applyStimulus(input logic r, input logic en, input logic [1:0] m,
                               input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RSTn = r;
      EN   = en;
      MODE = m;
      rst_hist.push_back(r);
      mode_hist.push_back(m);
      e = rst_hist.size() - 1;
      exp_q.push_back(model_edge(e, r, en));
    end
  endtask

  task automatic checkOutput(input logic [2:0] expv);
    logic [2:0] act;
    act = {PULSE_3, PULSE_2, PULSE_1};
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= MAX_FAIL_PRINTS)
        $display("[TB] FAIL pulses at %0t: got %b expected %b (P3P2P1)", $time, act, expv);
    end
    // Channels must never overlap in any mode.
    checks++;
    if ((int'(act[0]) + int'(act[1]) + int'(act[2])) > 1) begin
      errors++;
      if (errors <= MAX_FAIL_PRINTS)
        $display("[TB] FAIL overlap at %0t: got %b expected at most one high", $time, act);
    end
  endtask

  // Monitor: one comparison set per edge, sampled 1 ns after the rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    run_start = -1;
    RSTn = 1'b1;
    EN   = 1'b0;
    MODE = 2'd0;

    // 1: reset held with EN=1, then release into mode 0.
    applyStimulus(1'b1, 1'b1, 2'd0, 10);
    applyStimulus(1'b0, 1'b1, 2'd0, 300);
    // 2 / 6: register 0 = 0b110 after running, then enable into mode 3.
    applyStimulus(1'b0, 1'b0, 2'd3, 5);
    applyStimulus(1'b0, 1'b1, 2'd3, 300);
    // 3: mode 1 only drives PULSE_2.
    applyStimulus(1'b0, 1'b0, 2'd1, 2);
    applyStimulus(1'b0, 1'b1, 2'd1, 250);
    // 4: mode 0 -> 2 at cycle 50 while running.
    applyStimulus(1'b0, 1'b0, 2'd0, 2);
    applyStimulus(1'b0, 1'b1, 2'd0, 50);
    applyStimulus(1'b0, 1'b1, 2'd2, 250);
    // 5: EN dropped two cycles into a pulse, then re-raised.
    applyStimulus(1'b0, 1'b0, 2'd0, 3);
    applyStimulus(1'b0, 1'b1, 2'd0, 2);
    applyStimulus(1'b0, 1'b0, 2'd0, 3);
    applyStimulus(1'b0, 1'b1, 2'd0, 120);
    // Reset asserted mid-pulse while enabled and in mode 3.
    applyStimulus(1'b0, 1'b0, 2'd3, 2);
    applyStimulus(1'b0, 1'b1, 2'd3, 22);
    applyStimulus(1'b1, 1'b1, 2'd3, 1);
    applyStimulus(1'b0, 1'b1, 2'd3, 150);

    // Randomised segments: enable toggling, mode changes, occasional reset.
    for (int s = 0; s < 40; s++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)),
                    int'($urandom_range(1, 160)));
    end

    // Let the monitor drain the remaining entries, bounded by a few cycles.
    repeat (4) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
